// File: rtl/ex_mem_stage_p.sv
// Execute stage plus EX/MEM pipeline register for the LEGv8 pipeline.
// Operand forwarding, ALU, branch-target adder, CBZ-style branch resolve,
// and a valid/ready handshake with downstream stall and flush.
// Optional feature macro: EX_MUL_EN adds an iterative shift-add multiplier
// (alu_ctrl 1000) driven by an IDLE/MUL/DONE FSM. Without it, 1000 is an
// undefined op (result 0, single cycle) and the FSM stays in IDLE.
//
// Handshake: an E-stage instruction moves into EX/MEM on a rising edge where
// in_ready=1 (in_ready already implies in_valid in IDLE). A MUL is captured
// into the multiplier when it starts, but in_ready rises only in DONE, so the
// upstream stage keeps presenting it until then. stall_m freezes EX/MEM and
// blocks acceptance; flush kills the E-stage instruction and aborts a multiply.
module ex_mem_stage_p #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 10,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              stall_m,
  input  logic [5:0]        ctrl_e,
  input  logic [3:0]        alu_ctrl_e,
  input  logic [DATA_W-1:0] rd_data1_e,
  input  logic [DATA_W-1:0] rd_data2_e,
  input  logic [DATA_W-1:0] imm_e,
  input  logic [RA_W-1:0]   dest_reg_e,
  input  logic [PC_W-1:0]   pc_e,
  input  logic [DATA_W-1:0] result_w,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  output logic [PC_W-1:0]   pc_target,
  output logic              pc_src,
  output logic              valid_m,
  output logic [3:0]        ctrl_m,
  output logic [DATA_W-1:0] alu_result_m,
  output logic [RA_W-1:0]   dest_reg_m,
  output logic [DATA_W-1:0] store_data_m,
  output logic [1:0]        state_dbg
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // ctrl_e = {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}
  logic alu_src, branch;
  assign alu_src = ctrl_e[5];
  assign branch  = ctrl_e[0];

  logic [DATA_W-1:0] src_a, src_b_raw, src_b;
  logic [DATA_W-1:0] alu_out, ex_result;
  logic              zero;
  logic              is_mul_op;
  logic              mul_last;
  logic [DATA_W-1:0] mul_acc, mul_store;

  // Forwarding muxes; code 11 falls back to the register file like 00
  always_comb begin
    case (fwd_a)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_m;
      default: src_a = rd_data1_e;
    endcase
    case (fwd_b)
      2'b01:   src_b_raw = result_w;
      2'b10:   src_b_raw = alu_result_m;
      default: src_b_raw = rd_data2_e;
    endcase
    src_b = alu_src ? imm_e : src_b_raw;
  end

  // Single-cycle ALU; any code not listed (including MUL) yields 0
  always_comb begin
    alu_out = '0;
    case (alu_ctrl_e)
      OP_AND:   alu_out = src_a & src_b;
      OP_OR:    alu_out = src_a | src_b;
      OP_ADD:   alu_out = src_a + src_b;
      OP_SUB:   alu_out = src_a - src_b;
      OP_PASSB: alu_out = src_b;
      OP_NOR:   alu_out = ~(src_a | src_b);
      default:  alu_out = '0;
    endcase
  end

  // In DONE the finished product replaces the ALU output
  assign ex_result = (state_q == S_DONE) ? mul_acc : alu_out;
  assign zero      = (ex_result == '0);

  // Branch target and resolve; a MUL never redirects the PC
  assign pc_target = pc_e + {imm_e[PC_W-3:0], 2'b00};
  assign pc_src    = in_ready & branch & zero & ~is_mul_op;

`ifdef EX_MUL_EN
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mul_mcand, mul_mplier;
  logic [CNT_W-1:0]  mul_cnt;
  logic              mul_start;

  assign is_mul_op = (alu_ctrl_e == OP_MUL);
  assign mul_last  = (mul_cnt == CNT_W'(DATA_W - 1));
  assign mul_start = (state_q == S_IDLE) & in_valid & ~stall_m & ~flush & is_mul_op;

  // Shift-add multiplier: one multiplier bit per cycle, low DATA_W product bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_store  <= '0;
      mul_cnt    <= '0;
    end else if (mul_start) begin
      mul_acc    <= '0;
      mul_mcand  <= src_a;
      mul_mplier <= src_b;
      mul_store  <= src_b_raw;
      mul_cnt    <= '0;
    end else if (state_q == S_MUL) begin
      if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + 1'b1;
    end
  end
`else
  assign is_mul_op = 1'b0;
  assign mul_last  = 1'b0;
  assign mul_acc   = '0;
  assign mul_store = '0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and handshake; a stalled multiply keeps counting
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = in_valid & ~stall_m & ~flush & ~is_mul_op;
        if (in_valid & ~stall_m & ~flush & is_mul_op) state_d = S_MUL;
      end
      S_MUL: begin
        if (flush)         state_d = S_IDLE;
        else if (mul_last) state_d = S_DONE;
      end
      S_DONE: begin
        in_ready = ~stall_m & ~flush;
        if (flush | ~stall_m) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_dbg = state_q;

  // EX/MEM register: hold on stall, load on accept, otherwise insert a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_m      <= 1'b0;
      ctrl_m       <= '0;
      alu_result_m <= '0;
      dest_reg_m   <= '0;
      store_data_m <= '0;
    end else if (!stall_m) begin
      if (in_ready) begin
        valid_m      <= 1'b1;
        ctrl_m       <= ctrl_e[4:1];
        alu_result_m <= ex_result;
        dest_reg_m   <= dest_reg_e;
        store_data_m <= (state_q == S_DONE) ? mul_store : src_b_raw;
      end else begin
        valid_m <= 1'b0;
        ctrl_m  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_p.sv
// Self-checking bench for ex_mem_stage_p: directed cases plus randomized
// traffic checked against a behavioural model of the execute stage.
module tb_ex_mem_stage_p;

  localparam int DATA_W = 64;
  localparam int PC_W   = 10;
  localparam int RA_W   = 5;
  localparam int W      = 4 + RA_W + 2 * DATA_W;

`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  localparam int PH_IDLE = 0;
  localparam int PH_BUSY = 1;
  localparam int PH_DONE = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              stall_m = 1'b0;
  logic [5:0]        ctrl_e = '0;
  logic [3:0]        alu_ctrl_e = '0;
  logic [DATA_W-1:0] rd_data1_e = '0;
  logic [DATA_W-1:0] rd_data2_e = '0;
  logic [DATA_W-1:0] imm_e = '0;
  logic [RA_W-1:0]   dest_reg_e = '0;
  logic [PC_W-1:0]   pc_e = '0;
  logic [DATA_W-1:0] result_w = '0;
  logic [1:0]        fwd_a = '0;
  logic [1:0]        fwd_b = '0;
  logic [PC_W-1:0]   pc_target;
  logic              pc_src;
  logic              valid_m;
  logic [3:0]        ctrl_m;
  logic [DATA_W-1:0] alu_result_m;
  logic [RA_W-1:0]   dest_reg_m;
  logic [DATA_W-1:0] store_data_m;
  logic [1:0]        state_dbg;

  ex_mem_stage_p #(.DATA_W(DATA_W), .PC_W(PC_W), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .stall_m(stall_m), .ctrl_e(ctrl_e), .alu_ctrl_e(alu_ctrl_e),
    .rd_data1_e(rd_data1_e), .rd_data2_e(rd_data2_e), .imm_e(imm_e),
    .dest_reg_e(dest_reg_e), .pc_e(pc_e), .result_w(result_w),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_target(pc_target), .pc_src(pc_src),
    .valid_m(valid_m), .ctrl_m(ctrl_m), .alu_result_m(alu_result_m),
    .dest_reg_m(dest_reg_m), .store_data_m(store_data_m), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  logic              m_valid = 1'b0;
  logic [3:0]        m_ctrl = '0;
  logic [DATA_W-1:0] m_res = '0;
  int                m_phase = PH_IDLE;
  int                m_cnt = 0;
  logic [DATA_W-1:0] m_a = '0, m_b = '0, m_mstore = '0;
  logic              last_acc = 1'b0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] fwd_val(input logic [1:0] s,
                                                input logic [DATA_W-1:0] rf);
    case (s)
      2'b01:   return result_w;
      2'b10:   return m_res;
      default: return rf;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] alu_ref(input logic [3:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_PASSB: return b;
      OP_NOR:   return ~(a | b);
      default:  return '0;
    endcase
  endfunction

  // One clock of stimulus: called right after a falling edge with inputs set.
  task automatic tick();
    logic [DATA_W-1:0] a, braw, b, res, t;
    logic              is_mul, rdy, src, loaded;
    logic [W-1:0]      e;
    a      = fwd_val(fwd_a, rd_data1_e);
    braw   = fwd_val(fwd_b, rd_data2_e);
    b      = ctrl_e[5] ? imm_e : braw;
    is_mul = MUL_EN && (alu_ctrl_e == OP_MUL);
    res    = (m_phase == PH_DONE) ? m_a * m_b : alu_ref(alu_ctrl_e, a, b);
    case (m_phase)
      PH_IDLE: rdy = in_valid && !stall_m && !flush && !is_mul;
      PH_BUSY: rdy = 1'b0;
      default: rdy = !stall_m && !flush;
    endcase
    src = rdy && ctrl_e[0] && (res == '0) && !is_mul;
    t   = 64'(pc_e) + (imm_e << 2);
    #1;
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("pc_src", 64'(pc_src), 64'(src));
    check("pc_target", 64'(pc_target), 64'(t[PC_W-1:0]));
    loaded = 1'b0;
    if (!stall_m) begin
      if (rdy) begin
        m_valid = 1'b1;
        m_ctrl  = ctrl_e[4:1];
        m_res   = res;
        exp_q.push_back({ctrl_e[4:1], dest_reg_e, res,
                         (m_phase == PH_DONE) ? m_mstore : braw});
        loaded = 1'b1;
      end else begin
        m_valid = 1'b0;
        m_ctrl  = '0;
      end
    end
    case (m_phase)
      PH_IDLE: if (in_valid && !flush && !stall_m && is_mul) begin
        m_phase = PH_BUSY; m_cnt = DATA_W; m_a = a; m_b = b; m_mstore = braw;
      end
      PH_BUSY: if (flush) m_phase = PH_IDLE;
               else begin
                 m_cnt--;
                 if (m_cnt == 0) m_phase = PH_DONE;
               end
      default: if (flush || !stall_m) m_phase = PH_IDLE;
    endcase
    last_acc = rdy;
    @(posedge clk);
    #1;
    check("valid_m", 64'(valid_m), 64'(m_valid));
    check("ctrl_m", 64'(ctrl_m), 64'(m_ctrl));
    if (loaded) begin
      e = exp_q.pop_front();
      check("alu_result_m", alu_result_m, e[2*DATA_W-1:DATA_W]);
      check("store_data_m", store_data_m, e[DATA_W-1:0]);
      check("dest_reg_m", 64'(dest_reg_m), 64'(e[2*DATA_W+RA_W-1:2*DATA_W]));
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [3:0] op, input logic [DATA_W-1:0] r1,
                           input logic [DATA_W-1:0] r2, input logic [DATA_W-1:0] imm,
                           input logic [5:0] ctl, input logic [RA_W-1:0] rd,
                           input logic [PC_W-1:0] pc, input logic [1:0] fa,
                           input logic [1:0] fb);
    in_valid = 1'b1; stall_m = 1'b0; flush = 1'b0; result_w = '0;
    alu_ctrl_e = op; rd_data1_e = r1; rd_data2_e = r2; imm_e = imm;
    ctrl_e = ctl; dest_reg_e = rd; pc_e = pc; fwd_a = fa; fwd_b = fb;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; stall_m = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_valid_m", 64'(valid_m), 64'd0);
    check("rst_ctrl_m", 64'(ctrl_m), 64'd0);
    check("rst_alu_result_m", alu_result_m, 64'd0);
    check("rst_dest_reg_m", 64'(dest_reg_m), 64'd0);
    check("rst_store_data_m", store_data_m, 64'd0);
    m_valid = 1'b0; m_ctrl = '0; m_res = '0; m_phase = PH_IDLE; m_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_instr();
    int k;
    logic [3:0] ops[6] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_NOR};
    k = $urandom_range(0, 19);
    if (k == 0)      alu_ctrl_e = OP_MUL;
    else if (k == 1) alu_ctrl_e = 4'($urandom_range(0, 15));
    else             alu_ctrl_e = ops[k % 6];
    rd_data1_e = rand_val(); rd_data2_e = rand_val(); imm_e = rand_val();
    ctrl_e = 6'($urandom_range(0, 63)); dest_reg_e = RA_W'($urandom_range(0, 31));
    pc_e = PC_W'($urandom_range(0, 1023));
    fwd_a = 2'($urandom_range(0, 3)); fwd_b = 2'($urandom_range(0, 3));
    in_valid = ($urandom_range(0, 9) != 0);
  endtask

  // Forwarding from MEM is only meaningful while MEM holds a real instruction
  task automatic rand_cycle_ctrl();
    result_w = rand_val();
    stall_m  = ($urandom_range(0, 4) == 0);
    if (m_phase != PH_IDLE) flush = ($urandom_range(0, 149) == 0);
    else                    flush = ($urandom_range(0, 9) == 0);
    if (!m_valid && fwd_a == 2'b10) fwd_a = 2'b00;
    if (!m_valid && fwd_b == 2'b10) fwd_b = 2'b00;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clk);
    do_reset();

    // ADD 5+7 with reg_write
    set_instr(OP_ADD, 64'd5, 64'd7, 64'd0, 6'b001000, 5'd3, 10'd0, 2'b00, 2'b00);
    tick();
    check("t1_result", alu_result_m, 64'd12);
    check("t1_valid", 64'(valid_m), 64'd1);
    check("t1_reg_write", 64'(ctrl_m[2]), 64'd1);

    // Dependent ADD held by a 3-cycle stall, then released
    set_instr(OP_ADD, 64'd99, 64'd1, 64'd0, 6'b001000, 5'd4, 10'd0, 2'b10, 2'b00);
    stall_m = 1'b1;
    repeat (3) begin
      tick();
      check("t4_hold_result", alu_result_m, 64'd12);
      check("t4_hold_valid", 64'(valid_m), 64'd1);
    end
    stall_m = 1'b0;
    tick();
    check("t2_fwd_result", alu_result_m, 64'd13);

    // CBZ taken and not taken
    set_instr(OP_PASSB, 64'd0, 64'd0, 64'd3, 6'b000001, 5'd0, 10'h010, 2'b00, 2'b00);
    #1;
    check("t3_pc_target", 64'(pc_target), 64'h01C);
    check("t3_taken", 64'(pc_src), 64'd1);
    tick();
    set_instr(OP_PASSB, 64'd0, 64'd4, 64'd3, 6'b000001, 5'd0, 10'h010, 2'b00, 2'b00);
    #1;
    check("t3_not_taken", 64'(pc_src), 64'd0);
    tick();

    // Flushed instruction and idle cycle both leave a bubble
    set_instr(OP_ADD, 64'd1, 64'd1, 64'd0, 6'b001000, 5'd1, 10'd0, 2'b00, 2'b00);
    flush = 1'b1;
    tick();
    check("flush_bubble", 64'(valid_m), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("idle_bubble_ctrl", 64'(ctrl_m), 64'd0);

    set_instr(OP_OR, 64'hF0, 64'h0F, 64'd0, 6'b011110, 5'd9, 10'd0, 2'b00, 2'b00);
    tick();
    check("or_result", alu_result_m, 64'hFF);
    do_reset();

`ifdef EX_MUL_EN
    begin
      int n;
      set_instr(OP_MUL, 64'd6, 64'd7, 64'd0, 6'b001000, 5'd2, 10'd0, 2'b00, 2'b00);
      tick();
      n = 0;
      while (!valid_m && n < 200) begin tick(); n++; end
      check("mul_latency", 64'(n), 64'(DATA_W + 1));
      check("mul_6x7", alu_result_m, 64'd42);
      in_valid = 1'b0;
      tick();

      set_instr(OP_MUL, '1, 64'd2, 64'd0, 6'b001000, 5'd2, 10'd0, 2'b00, 2'b00);
      tick();
      n = 0;
      while (!valid_m && n < 200) begin tick(); n++; end
      check("mul_ones_x2", alu_result_m, 64'hFFFF_FFFF_FFFF_FFFE);
      in_valid = 1'b0;
      tick();

      set_instr(OP_MUL, 64'd3, 64'd5, 64'd0, 6'b001000, 5'd2, 10'd0, 2'b00, 2'b00);
      repeat (10) tick();
      flush = 1'b1;
      tick();
      check("mul_flush_valid", 64'(valid_m), 64'd0);
      flush = 1'b0; in_valid = 1'b0;
      repeat (3) tick();
      check("mul_flush_no_write", alu_result_m, 64'hFFFF_FFFF_FFFF_FFFE);

      set_instr(OP_MUL, 64'd9, 64'd9, 64'd0, 6'b001000, 5'd2, 10'd0, 2'b00, 2'b00);
      repeat (20) tick();
      do_reset();
    end
`endif

    // Randomized traffic
    rand_instr();
    repeat (1500) begin
      rand_cycle_ctrl();
      tick();
      if (last_acc || flush || !in_valid) rand_instr();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
